// File: rtl/matmul_stream_pe.sv
// matmul_stream_pe: streamed signed fixed-point DIMxDIM matrix multiplier.
// Operands A then B arrive row-major on a valid/ready input stream. They land in
// local buffers. A bank of DIM MAC lanes then builds one row of C every DIM cycles.
// Each finished sum is rescaled by FRAC_BITS (floor). It is then saturated or
// wrapped to W bits. C is streamed out row-major on a valid/ready output stream.
module matmul_stream_pe #(
    parameter int INT_BITS  = 7,
    parameter int FRAC_BITS = 9,
    parameter int DIM       = 16,
    parameter int SAT_EN    = 1,
    localparam int W        = INT_BITS + FRAC_BITS,
    localparam int ACC_W    = 2 * W + $clog2(DIM)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         busy,
    output logic         done,
    output logic         ovf
);

    localparam int DIM_W = $clog2(DIM);
    localparam logic [DIM_W-1:0] LAST = DIM_W'(DIM - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_COMPUTE = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    // Clamp limits, sign-extended to accumulator width for signed compares.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    logic [1:0]       state;
    logic [DIM_W-1:0] row;
    logic [DIM_W-1:0] col;
    logic             load_b;

    logic signed [W-1:0]     a_mem [DIM][DIM];
    logic signed [W-1:0]     b_mem [DIM][DIM];
    logic signed [W-1:0]     c_mem [DIM][DIM];
    logic signed [ACC_W-1:0] acc   [DIM];

    logic signed [2*W-1:0]   prod    [DIM];
    logic signed [ACC_W-1:0] sum     [DIM];
    logic signed [ACC_W-1:0] shifted [DIM];
    logic signed [W-1:0]     fmt     [DIM];
    logic [DIM-1:0]          lane_ovf;

    logic             in_fire;
    logic             out_fire;
    logic             row_end;
    logic             last_elem;
    logic [DIM_W-1:0] next_row;
    logic [DIM_W-1:0] next_col;

    // The handshake outputs are pure decodes of the state.
    // An asynchronous reset therefore drops them at once.
    assign in_ready  = (state == S_LOAD);
    assign out_valid = (state == S_OUT);
    assign busy      = (state != S_IDLE);
    assign out_data  = out_valid ? c_mem[row][col] : '0;

    assign in_fire   = in_ready && in_valid;
    assign out_fire  = out_valid && out_ready;
    assign row_end   = (col == LAST);
    assign last_elem = row_end && (row == LAST);

    // Row-major walk over a DIMxDIM grid.
    // The same row/col pair is reused for loading, for (i,k) in compute, and for unloading.
    always_comb begin
        next_col = row_end ? '0 : col + 1'b1;
        next_row = row;
        if (row_end) begin
            next_row = (row == LAST) ? '0 : row + 1'b1;
        end
    end

    // MAC lanes: lane j accumulates A[i][k]*B[k][j].
    // The lane also formats the running sum so it can be stored when k reaches DIM-1.
    always_comb begin
        lane_ovf = '0;
        for (int j = 0; j < DIM; j++) begin
            prod[j]    = a_mem[row][col] * b_mem[col][j];
            sum[j]     = acc[j] + $signed({{(ACC_W-2*W){prod[j][2*W-1]}}, prod[j]});
            shifted[j] = sum[j] >>> FRAC_BITS;
            fmt[j]     = shifted[j][W-1:0];
            if (SAT_EN != 0) begin
                if (shifted[j] > SAT_MAX) begin
                    fmt[j]      = SAT_MAX[W-1:0];
                    lane_ovf[j] = 1'b1;
                end else if (shifted[j] < SAT_MIN) begin
                    fmt[j]      = SAT_MIN[W-1:0];
                    lane_ovf[j] = 1'b1;
                end
            end else begin
                lane_ovf[j] = (shifted[j] != $signed({{(ACC_W-W){fmt[j][W-1]}}, fmt[j]}));
            end
        end
    end

    // Control FSM, walk counters, accumulators, the sticky overflow flag and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            row    <= '0;
            col    <= '0;
            load_b <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
            for (int j = 0; j < DIM; j++) begin
                acc[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        row    <= '0;
                        col    <= '0;
                        load_b <= 1'b0;
                        ovf    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        row <= next_row;
                        col <= next_col;
                        if (last_elem) begin
                            if (load_b) begin
                                load_b <= 1'b0;
                                state  <= S_COMPUTE;
                            end else begin
                                load_b <= 1'b1;
                            end
                        end
                    end
                end
                S_COMPUTE: begin
                    row <= next_row;
                    col <= next_col;
                    for (int j = 0; j < DIM; j++) begin
                        acc[j] <= row_end ? '0 : sum[j];
                    end
                    if (row_end && (lane_ovf != '0)) begin
                        ovf <= 1'b1;
                    end
                    if (last_elem) begin
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_fire) begin
                        row <= next_row;
                        col <= next_col;
                        if (last_elem) begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand and result buffers.
    // These have no reset: every element is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (load_b) begin
                b_mem[row][col] <= in_data;
            end else begin
                a_mem[row][col] <= in_data;
            end
        end
        if ((state == S_COMPUTE) && row_end) begin
            for (int j = 0; j < DIM; j++) begin
                c_mem[row][j] <= fmt[j];
            end
        end
    end

endmodule

// File: tb/tb_matmul_stream_pe.sv
// tb_matmul_stream_pe: directed bench for matmul_stream_pe at DIM=4, Q7.9, saturating.
// A behavioural model computes each C element when operands are chosen.
// The bench queues the expected elements and pops one for every element the DUT hands over.
module tb_matmul_stream_pe;

    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 9;
    localparam int DIM       = 4;
    localparam int SAT_EN    = 1;
    localparam int W         = INT_BITS + FRAC_BITS;
    localparam int N         = DIM * DIM;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         start     = 1'b0;
    logic         in_valid  = 1'b0;
    logic [W-1:0] in_data   = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;
    logic         done;
    logic         ovf;

    logic [W-1:0] a_m [DIM][DIM];
    logic [W-1:0] b_m [DIM][DIM];
    logic [W-1:0] exp_q [$];
    logic         exp_ovf;

    int total    = 0;
    int bad      = 0;
    int done_cnt = 0;
    int cycles   = 0;

    matmul_stream_pe #(
        .INT_BITS (INT_BITS),
        .FRAC_BITS(FRAC_BITS),
        .DIM      (DIM),
        .SAT_EN   (SAT_EN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Count every cycle in which done is high. A pulse must bump this exactly once.
    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    // Backstop against a hung handshake.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic setAll(input logic [W-1:0] av, input logic [W-1:0] bv);
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a_m[r][c] = av;
                b_m[r][c] = bv;
            end
        end
    endtask

    task automatic setRandom();
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                a_m[r][c] = W'($urandom);
                b_m[r][c] = W'($urandom);
            end
        end
    endtask

    // Reference: exact integer dot product, floor-divide by 2^FRAC_BITS, then clamp to W bits.
    task automatic computeExpected();
        longint s;
        longint q;
        logic [W-1:0] r;
        exp_ovf = 1'b0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) begin
                    s += longint'($signed(a_m[i][k])) * longint'($signed(b_m[k][j]));
                end
                q = s >>> FRAC_BITS;
                if (q > 32767) begin
                    r = 16'h7FFF;
                    exp_ovf = 1'b1;
                end else if (q < -32768) begin
                    r = 16'h8000;
                    exp_ovf = 1'b1;
                end else begin
                    r = q[15:0];
                end
                exp_q.push_back(r);
            end
        end
    endtask

    task automatic loadOperands(input bit gaps, input bit poke);
        int n = 0;
        int guard = 0;
        bit took;
        bit poked;
        while (n < 2 * N && guard < 1000) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n < N) in_data = a_m[n / DIM][n % DIM];
            else       in_data = b_m[(n - N) / DIM][(n - N) % DIM];
            poked = poke && (n == 7);
            start = poked;
            took  = in_valid && in_ready;
            @(posedge clk); #1;
            cycles++;
            guard++;
            start = 1'b0;
            if (took) n++;
            if (poked) checkOutput("poke_load_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        checkOutput("load_count", n, 2 * N);
    endtask

    task automatic waitCompute(input bit poke);
        int guard = 0;
        while (!out_valid && guard < 100) begin
            start = poke && (guard == 4);
            @(posedge clk); #1;
            cycles++;
            guard++;
            start = 1'b0;
        end
        checkOutput("wait_out_valid", out_valid, 1);
        // The accept cycle plus the edges waited gives the latency in cycles.
        checkOutput("first_out_latency", guard + 1, N + 1);
    endtask

    task automatic collectResults(input bit stalls, input bit poke);
        int k = 0;
        int guard = 0;
        bit rdy;
        bit holding = 1'b0;
        logic [W-1:0] held;
        logic [W-1:0] e;
        while (k < N && guard < 1000) begin
            if (holding) checkOutput("hold_data", out_data, held);
            rdy = stalls ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            start = poke && (k == 5);
            if (out_valid && rdy) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = 'x;
                checkOutput("c_elem", out_data, e);
                k++;
                holding = 1'b0;
            end else begin
                held = out_data;
                holding = 1'b1;
            end
            @(posedge clk); #1;
            cycles++;
            guard++;
            start = 1'b0;
            out_ready = 1'b0;
        end
        checkOutput("out_count", k, N);
    endtask

    task automatic applyStimulus(input bit gaps, input bit stalls, input bit poke);
        int d0;
        exp_q.delete();
        computeExpected();
        d0 = done_cnt;
        cycles = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1;
        checkOutput("start_in_ready", in_ready, 1);
        checkOutput("ovf_cleared", ovf, 0);
        loadOperands(gaps, poke);
        waitCompute(poke);
        collectResults(stalls, poke);
        if (!gaps && !stalls) checkOutput("run_cycles", cycles, 1 + 2 * N + N + N);
        checkOutput("done_high", done, 1);
        checkOutput("idle_out_valid", out_valid, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("ovf_final", ovf, exp_ovf);
        @(posedge clk); #1;
        checkOutput("done_low", done, 0);
        checkOutput("done_once", done_cnt, d0 + 1);
    endtask

    initial begin
        $display("[TB] reset");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] identity A times ramp B");
        setAll('0, '0);
        for (int r = 0; r < DIM; r++) begin
            a_m[r][r] = 16'h0200;
            for (int c = 0; c < DIM; c++) b_m[r][c] = W'(16 * r + c);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] rounding toward minus infinity");
        setAll('0, '0);
        a_m[0][0] = 16'h0001;
        b_m[0][0] = 16'h0100;
        applyStimulus(1'b0, 1'b0, 1'b0);
        a_m[0][0] = 16'hFFFF;
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] saturation");
        setAll(16'h7FFF, 16'h7FFF);
        applyStimulus(1'b0, 1'b0, 1'b0);
        setAll(16'h8000, 16'h7FFF);
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] random operands with gaps and backpressure");
        setRandom();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        setRandom();
        applyStimulus(1'b1, 1'b1, 1'b0);

        $display("[TB] start pulses outside idle");
        setRandom();
        applyStimulus(1'b0, 1'b0, 1'b1);

        $display("[TB] reset during compute");
        begin
            int d0;
            setAll(16'h7FFF, 16'h7FFF);
            exp_q.delete();
            d0 = done_cnt;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            loadOperands(1'b0, 1'b0);
            repeat (6) begin
                @(posedge clk); #1;
            end
            checkOutput("pre_rst_busy", busy, 1);
            checkOutput("pre_rst_ovf", ovf, 1);
            rst = 1'b1;
            #1;
            checkOutput("abort_in_ready", in_ready, 0);
            checkOutput("abort_out_valid", out_valid, 0);
            checkOutput("abort_out_data", out_data, 0);
            checkOutput("abort_busy", busy, 0);
            checkOutput("abort_done", done, 0);
            checkOutput("abort_ovf", ovf, 0);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (20) @(posedge clk);
            #1;
            checkOutput("abort_no_done", done_cnt, d0);
            checkOutput("abort_idle", busy, 0);
        end
        setRandom();
        applyStimulus(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matmul_stream_pe.md
Name: matmul_stream_pe

Overview:
- Sequential fixed-point square matrix multiplier: C = A × B, all matrices DIM×DIM, signed Q(INT_BITS.FRAC_BITS).
- Operands are streamed in and the result is streamed out over valid/ready interfaces, instead of flat array ports.
- A row of DIM MAC lanes computes one output row per DIM cycles, with rounding and saturation handled explicitly.
- Sits between the operand loader and the result writer in the PE datapath; the start/busy/done handshake is owned by the system controller.

Parameters:
- INT_BITS, 7, integer bits of every element, including the sign bit.
- FRAC_BITS, 9, fractional bits of every element.
- DIM, 16, matrix dimension; legal range 2..32.
- SAT_EN, 1, 1 = saturate results to W bits; 0 = wrap (keep the low W bits).
- Derived: W = INT_BITS+FRAC_BITS; ACC_W = 2*W + clog2(DIM).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- in_valid  in  1  operand element valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  W  signed element; all of A in row-major order, then all of B in row-major order.
- out_valid  out  1  result element valid.
- out_ready  in  1  downstream accepts the result element.
- out_data  out  W  signed C element, row-major order.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse after the last C element is accepted.
- ovf  out  1  sticky saturation/wrap flag; cleared when start is accepted.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, ovf=0; state=IDLE; counters and accumulators cleared.
- Buffer contents (A, B, C) are not reset.
- Reset asserted in any state aborts the operation immediately; no done pulse is issued.
- States: IDLE → LOAD → COMPUTE → OUT → IDLE.
- IDLE:
  - start=1 → LOAD next cycle; clear ovf and the element counter.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1; an element is written on each cycle with in_valid&in_ready.
  - Counter 0..DIM²-1 writes A[r][c]; counter DIM²..2·DIM²-1 writes B[r][c].
  - Gaps in in_valid stall the load; there is no timeout.
  - The cycle that accepts the last element transitions to COMPUTE.
- COMPUTE:
  - Row index i = 0..DIM-1; k = 0..DIM-1, one k per cycle.
  - Every cycle, for all j in parallel: acc[j] += A[i][k]*B[k][j].
  - Products are full 2W-bit signed; acc is ACC_W bits and never overflows.
  - On k = DIM-1, the final sum (acc + last product) is written to C[i][j] in the same cycle, and acc clears.
  - Exactly DIM² cycles in COMPUTE, then OUT.
- Result formatting:
  - Arithmetic right shift of the sum by FRAC_BITS, i.e. truncation toward −∞.
  - If SAT_EN=1: clamp to [−2^(W−1), 2^(W−1)−1] and set ovf if the clamp was applied.
  - If SAT_EN=0: keep the low W bits and set ovf if the value changed.
- OUT:
  - out_valid=1 with out_data = C[idx], where idx runs 0..DIM²-1 in row-major order.
  - idx advances only on out_valid&out_ready.
  - out_data stays stable while out_valid=1 and out_ready=0.
  - The handshake on idx = DIM²-1 returns to IDLE; done=1 on the following cycle (first IDLE cycle); out_valid=0 from that cycle.
- start in the same cycle as done is accepted (the state is IDLE).
- Latency with no stalls: start → first in_ready is 1 cycle; last input accepted → first out_valid is DIM²+1 cycles.

Test Plan:
- DIM=4, A=I (diagonal 0x0200, others 0), B[r][c]=16·r+c in LSBs → C equals B exactly; ovf=0; done pulses once; total time from start to done with no stalls is 1 + 32 + 16 + 16 (+1 for done) cycles.
- Rounding, DIM=4: A[0][0]=0x0001, B[0][0]=0x0100, all else 0 → C[0][0]=0x0000. Repeat with A[0][0]=0xFFFF → C[0][0]=0xFFFF (floor of −2⁻¹⁰). ovf stays 0 in both runs.
- Saturation, SAT_EN=1: A and B all 0x7FFF → every C element = 0x7FFF, ovf=1. Then A all 0x8000, B all 0x7FFF → every C element = 0x8000. ovf was cleared by the second start and is set again.
- Backpressure and gaps:
  - Random in_valid gaps and out_ready low 50% of cycles → the C stream is identical to the stall-free run.
  - out_data is held constant during every stall.
- start pulsed during LOAD, COMPUTE and OUT → ignored: no state or counter change, done count stays 1.
- rst asserted mid-COMPUTE → all outputs at reset values the same cycle. A new start then performs a full correct run with fresh operands.
